// File: rtl/dft_bin_mac.sv
// Single-bin 32-point DFT engine: one complex MAC per clock over a captured frame,
// then bin power from the Q15-descaled real/imaginary sums.
//
//  state  | meaning
//  -------+---------------------------------------------------------------
//  S_IDLE | waiting for start; last results held on the outputs
//  S_MAC  | accumulating x[n]*cos and -x[n]*sin, one sample per clock
//  S_POW  | descale accumulators, compute power, pulse done
module dft_bin_mac #(
    parameter int N  = 32,
    parameter int DW = 16,
    parameter int AW = 40
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [4:0]              k,
    input  logic [N*DW-1:0]         samples,
    output logic                    busy,
    output logic                    done,
    output logic signed [23:0]      re_out,
    output logic signed [23:0]      im_out,
    output logic [47:0]             pow_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_POW  = 2'd2
    } state_t;

    state_t                 r_state;
    logic [N*DW-1:0]        r_frame;
    logic [4:0]             r_k;
    logic [4:0]             r_n;
    logic signed [AW-1:0]   r_acc_re;
    logic signed [AW-1:0]   r_acc_im;

    logic [4:0]             w_m;
    logic [4:0]             w_m_sin;
    logic signed [DW-1:0]   w_x;
    logic signed [15:0]     w_cos;
    logic signed [15:0]     w_sin;
    logic [31:0]            w_x32;
    logic [31:0]            w_cos32;
    logic [31:0]            w_sin32;
    logic [31:0]            w_prod_re;
    logic [31:0]            w_prod_im;
    logic [AW-1:0]          w_prod_re_ext;
    logic [AW-1:0]          w_prod_im_ext;
    logic signed [23:0]     w_re;
    logic signed [23:0]     w_im;
    logic [47:0]            w_re48;
    logic [47:0]            w_im48;
    logic [47:0]            w_pow;

    // Quarter-wave cosine ROM, Q15
    function automatic logic signed [15:0] qrom(input logic [3:0] i);
        logic signed [15:0] v;
        case (i)
            4'd0:    v = 16'sd32767;
            4'd1:    v = 16'sd32137;
            4'd2:    v = 16'sd30273;
            4'd3:    v = 16'sd27245;
            4'd4:    v = 16'sd23170;
            4'd5:    v = 16'sd18205;
            4'd6:    v = 16'sd12540;
            4'd7:    v = 16'sd6393;
            default: v = 16'sd0;
        endcase
        return v;
    endfunction

    // Full-wave cosine by quadrant folding of the quarter-wave ROM
    function automatic logic signed [15:0] cos_tab(input logic [4:0] m);
        logic [3:0]         r;
        logic [3:0]         rr;
        logic signed [15:0] v;
        r  = {1'b0, m[2:0]};
        rr = 4'd8 - r;
        case (m[4:3])
            2'd0:    v = qrom(r);
            2'd1:    v = -qrom(rr);
            2'd2:    v = -qrom(r);
            default: v = qrom(rr);
        endcase
        return v;
    endfunction

    assign w_m     = r_k * r_n;
    assign w_m_sin = w_m - 5'd8;
    assign w_x     = r_frame[{r_n, 4'b0000} +: DW];
    assign w_cos   = cos_tab(w_m);
    assign w_sin   = cos_tab(w_m_sin);

    // Operands widened to 32 bits so the low half of the product is exact
    assign w_x32         = {{(32-DW){w_x[DW-1]}}, w_x};
    assign w_cos32       = {{16{w_cos[15]}}, w_cos};
    assign w_sin32       = {{16{w_sin[15]}}, w_sin};
    assign w_prod_re     = w_x32 * w_cos32;
    assign w_prod_im     = w_x32 * w_sin32;
    assign w_prod_re_ext = {{(AW-32){w_prod_re[31]}}, w_prod_re};
    assign w_prod_im_ext = {{(AW-32){w_prod_im[31]}}, w_prod_im};

    assign w_re   = r_acc_re[38:15];
    assign w_im   = r_acc_im[38:15];
    assign w_re48 = {{24{w_re[23]}}, w_re};
    assign w_im48 = {{24{w_im[23]}}, w_im};
    assign w_pow  = (w_re48 * w_re48) + (w_im48 * w_im48);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_frame  <= '0;
            r_k      <= '0;
            r_n      <= '0;
            r_acc_re <= '0;
            r_acc_im <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            re_out   <= '0;
            im_out   <= '0;
            pow_out  <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_frame  <= samples;
                        r_k      <= k;
                        r_n      <= '0;
                        r_acc_re <= '0;
                        r_acc_im <= '0;
                        busy     <= 1'b1;
                        r_state  <= S_MAC;
                    end
                end
                S_MAC: begin
                    r_acc_re <= r_acc_re + $signed(w_prod_re_ext);
                    r_acc_im <= r_acc_im - $signed(w_prod_im_ext);
                    r_n      <= r_n + 5'd1;
                    if (r_n == 5'(N-1)) begin
                        r_state <= S_POW;
                    end
                end
                S_POW: begin
                    re_out  <= w_re;
                    im_out  <= w_im;
                    pow_out <= w_pow;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dft_bin_mac.sv
// Directed scoreboard bench for dft_bin_mac: expected bins are queued at
// stimulus time and checked by an independent monitor on each done pulse.
module tb_dft_bin_mac;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [4:0]         k;
    logic [511:0]       samples;
    logic               busy;
    logic               done;
    logic signed [23:0] re_out;
    logic signed [23:0] im_out;
    logic [47:0]        pow_out;

    always #5 clk = ~clk;

    dft_bin_mac dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .k       (k),
        .samples (samples),
        .busy    (busy),
        .done    (done),
        .re_out  (re_out),
        .im_out  (im_out),
        .pow_out (pow_out)
    );

    typedef struct {
        longint re;
        longint im;
        longint pw;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   n_done = 0;
    int   n_exp  = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (!rst && done) begin
            n_done++;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=1 expected=0");
            end else begin
                mon_e = sb_q.pop_front();
                chk("re_out", longint'(re_out), mon_e.re);
                chk("im_out", longint'(im_out), mon_e.im);
                chk("pow_out", longint'(pow_out), mon_e.pw);
            end
        end
    end

    function automatic logic [511:0] fill(input int ev, input int od);
        logic [511:0] f;
        f = '0;
        for (int n = 0; n < 32; n++) begin
            f[n*16 +: 16] = (n % 2 == 0) ? 16'(ev) : 16'(od);
        end
        return f;
    endfunction

    function automatic logic [511:0] impulse(input int idx, input int v);
        logic [511:0] f;
        f = '0;
        f[idx*16 +: 16] = 16'(v);
        return f;
    endfunction

    // mode 0: plain frame; 1: stray start with new inputs at MAC cycle 10;
    // 2: reset at MAC cycle 12, no result expected
    task automatic run(input logic [511:0] f, input logic [4:0] kk,
                       input longint er, input longint ei, input longint ep,
                       input int mode, input string tag);
        int lat;
        bit got;
        bit busy_bad;
        @(posedge clk);
        #1;
        samples = f;
        k       = kk;
        start   = 1'b1;
        if (mode != 2) begin
            sb_q.push_back('{er, ei, ep});
            n_exp++;
        end
        @(posedge clk);
        #1;
        start    = 1'b0;
        lat      = 0;
        got      = 1'b0;
        busy_bad = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
            if (!busy) busy_bad = 1'b1;
            if (mode == 1) begin
                start = (lat == 10);
                if (lat == 10) begin
                    samples = fill(-77, 55);
                    k       = 5'd7;
                end
            end
            if (mode == 2 && lat == 12) begin
                rst = 1'b1;
                #1;
                chk({tag, "_rst_busy"}, longint'(busy), 0);
                chk({tag, "_rst_done"}, longint'(done), 0);
                chk({tag, "_rst_re"}, longint'(re_out), 0);
                chk({tag, "_rst_im"}, longint'(im_out), 0);
                chk({tag, "_rst_pow"}, longint'(pow_out), 0);
                break;
            end
            lat++;
        end
        if (mode == 2) begin
            repeat (2) @(negedge clk);
            rst = 1'b0;
        end else begin
            start = 1'b0;
            chk({tag, "_done_seen"}, longint'(got), 1);
            chk({tag, "_latency"}, longint'(lat), 33);
            chk({tag, "_busy_during"}, longint'(busy_bad), 0);
            chk({tag, "_busy_at_done"}, longint'(busy), 0);
            @(negedge clk);
            chk({tag, "_done_clear"}, longint'(done), 0);
        end
    endtask

    initial begin
        int lat;
        rst     = 1'b1;
        start   = 1'b0;
        k       = '0;
        samples = '0;
        repeat (2) @(negedge clk);
        chk("reset_busy", longint'(busy), 0);
        chk("reset_done", longint'(done), 0);
        chk("reset_re", longint'(re_out), 0);
        chk("reset_im", longint'(im_out), 0);
        chk("reset_pow", longint'(pow_out), 0);
        rst = 1'b0;

        run(fill(1000, 1000), 5'd0, 31999, 0, 1023936001, 0, "t1_dc");
        run(impulse(0, 1000), 5'd5, 999, 0, 998001, 0, "t2_imp0");
        run(impulse(8, 1000), 5'd1, 0, -1000, 1000000, 0, "t3_floor");
        run(fill(1000, -1000), 5'd16, 31999, 0, 1023936001, 0, "t4_nyq");
        run(fill(1000, -1000), 5'd0, 0, 0, 0, 0, "t4_alt_dc");
        run(fill(1000, 1000), 5'd0, 31999, 0, 1023936001, 1, "t5_ignore");
        repeat (40) @(negedge clk);
        run(fill(1000, 1000), 5'd0, 0, 0, 0, 2, "t6_abort");
        run(impulse(0, 1000), 5'd5, 999, 0, 998001, 0, "t6_rerun");

        // Back-to-back frames with start held high; inputs swapped between frames
        @(posedge clk);
        #1;
        samples = fill(1000, 1000);
        k       = 5'd0;
        start   = 1'b1;
        sb_q.push_back('{31999, 0, 1023936001});
        sb_q.push_back('{999, 0, 998001});
        sb_q.push_back('{0, -1000, 1000000});
        n_exp += 3;
        @(posedge clk);
        #1;
        for (int f = 0; f < 3; f++) begin
            lat = 0;
            for (int i = 0; i < 60; i++) begin
                @(negedge clk);
                if (done) break;
                lat++;
            end
            chk($sformatf("t7_spacing_%0d", f), longint'(lat), 33);
            if (f == 0) begin
                samples = impulse(0, 1000);
                k       = 5'd5;
            end else if (f == 1) begin
                samples = impulse(8, 1000);
                k       = 5'd1;
            end else begin
                start = 1'b0;
            end
        end

        repeat (40) @(negedge clk);
        chk("done_count", longint'(n_done), longint'(n_exp));
        chk("sb_empty", longint'(sb_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dft_bin_mac.md
Name: dft_bin_mac

Overview:
- Downstream consumer of the 32-sample serial-to-parallel frame buffer in the THDi computation path.
- On a start pulse (driven by the buffer's done), captures the 32 signed 16-bit samples and a harmonic index k.
- Serially computes the single DFT bin X[k] = sum x[n]·e^(-j2πkn/32) over the frame.
- Returns scaled real/imaginary parts and bin power for the THD ratio stage.

Parameters:
N, 32, frame length; only 32 is supported, index width fixed at 5 bits
DW, 16, sample width (signed two's complement)
AW, 40, accumulator width (signed)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  frame-ready pulse; sampled only in IDLE
k  input  5  harmonic index, captured with start
samples  input  512  packed frame; sample n at bits [16n+15:16n], signed
busy  output  1  high while a frame is being processed
done  output  1  one-cycle pulse when results are valid
re_out  output  24  signed Re(X[k]), accumulator arithmetic-shifted right 15
im_out  output  24  signed Im(X[k]), same scaling
pow_out  output  48  unsigned re_out² + im_out²

Behaviour:
- Reset (async, any state): state=IDLE, busy=0, done=0, re_out=0, im_out=0, pow_out=0, accumulators=0, sample index=0.
- States: IDLE, MAC, POW.
- IDLE:
  - If start=1 at edge E0: latch samples and k into internal registers, clear both accumulators, set index n=0, set busy=1, go to MAC.
  - Otherwise hold. Outputs keep their last results.
- MAC (edges E1..E32, one sample per cycle):
  - m = (k·n) mod 32 (low 5 bits of the product).
  - acc_re += x[n]·cos_tab(m); acc_im −= x[n]·sin_tab(m). Products are 32-bit signed, sign-extended to AW.
  - After n=31 is accumulated, go to POW.
- POW (edge E33):
  - re_out = acc_re[38:15], im_out = acc_im[38:15] (arithmetic shift, floor toward −∞, no rounding).
  - pow_out = square of the registered-value re plus square of the im, computed from the shifted values in the same cycle.
  - done=1, busy=0, go to IDLE.
  - done returns to 0 at E34.
- Latency: done is high in the cycle following edge E33, i.e. 33 clocks after the start-accepting edge.
- Minimum start-to-start spacing is 34 clocks.
- Trig tables:
  - Quarter-wave Q15 ROM for i=0..8: 32767, 32137, 30273, 27245, 23170, 18205, 12540, 6393, 0.
  - cos_tab(m) by quadrant q=m[4:3], r=m[2:0]:
    - q0: Q[r]
    - q1: −Q[8−r]
    - q2: −Q[r]
    - q3: Q[8−r]
  - sin_tab(m) = cos_tab((m−8) mod 32).
- start in MAC or POW: ignored, no queuing. The captured frame and k are unaffected by later changes on samples or k.
- start held high continuously: accepted at every IDLE edge, giving back-to-back frames every 34 clocks.
- No overflow possible:
  - |accumulator| < 2^36.
  - Shifted results lie within ±2^21 and fit 24 bits.
  - Power < 2^43 and fits 48 bits.
- Reset asserted mid-MAC: frame is abandoned, no done pulse, outputs cleared. The next start after reset release is processed normally.

Test Plan:
1. All samples=1000, k=0 -> done 33 clocks after start; re_out=31999, im_out=0, pow_out=1023936001.
2. x[0]=1000, all others 0, k=5 -> re_out=999, im_out=0, pow_out=998001.
3. x[8]=1000, all others 0, k=1 -> re_out=0, im_out=−1000 (floor check), pow_out=1000000.
4. Alternating x[n]=+1000 (n even) / −1000 (n odd):
   - k=16 -> re_out=31999, im_out=0.
   - k=0 -> re_out=0, im_out=0, pow_out=0.
5. Test 1 frame, then change samples and k and pulse start again at MAC cycle 10 -> results unchanged from test 1, exactly one done pulse, busy high continuously from E0 to E33.
6. Assert rst at MAC cycle 12 -> busy, done and all outputs 0 immediately, no done pulse. Release reset and rerun test 2 -> same values as test 2.
7. start held high for 3 frames -> done pulses exactly 34 clocks apart, each with correct results.
